// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input and decode output.
// The master modport is the fetch stage's view; slave is the memory/decode/datapath side.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [5:0]  id_op;
  logic [5:0]  id_funct;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_op, id_funct,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_op, id_funct,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited in-order fetch, response buffer to decode,
// and redirect flushing with a drop counter for in-flight wrong-path responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0] DepthC = FIFO_DEPTH[CntW:0];

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0] pq_wptr_q, pq_wptr_d, pq_rptr_q, pq_rptr_d;
  logic [PtrW-1:0] fq_wptr_q, fq_wptr_d, fq_rptr_q, fq_rptr_d;

  logic [31:0] pq_mem_q    [FIFO_DEPTH];
  logic [31:0] fq_instr_q  [FIFO_DEPTH];
  logic [31:0] fq_pc_q     [FIFO_DEPTH];

  logic [CntW:0] inflight;
  logic credit, req_valid, req_fire, resp_fire, drop, push, id_valid, pop, redirect;

  always_comb begin
    redirect  = bus.redirect_valid;
    // Responses plus buffered words never exceed the buffer, so a response always has room.
    inflight  = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
    credit    = inflight < DepthC;
    req_valid = credit & ~redirect & ~rst;
    req_fire  = req_valid & bus.imem_req_ready;
    resp_fire = bus.imem_resp_valid & (outstanding_q != '0);
    drop      = resp_fire & (drop_cnt_q != '0);
    push      = resp_fire & ~drop & ~redirect;
    id_valid  = (fifo_cnt_q != '0) & ~rst;
    pop       = id_valid & bus.id_ready & ~redirect;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(resp_fire);
    drop_cnt_d    = drop_cnt_q;
    fifo_cnt_d    = fifo_cnt_q + CntW'(push) - CntW'(pop);
    pq_wptr_d     = req_fire  ? pq_wptr_q + PtrW'(1) : pq_wptr_q;
    pq_rptr_d     = resp_fire ? pq_rptr_q + PtrW'(1) : pq_rptr_q;
    fq_wptr_d     = push ? fq_wptr_q + PtrW'(1) : fq_wptr_q;
    fq_rptr_d     = pop  ? fq_rptr_q + PtrW'(1) : fq_rptr_q;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (drop) begin
      drop_cnt_d = drop_cnt_q - CntW'(1);
    end

    if (redirect) begin
      fetch_pc_d = bus.redirect_pc & ~32'h3;
      // Nothing issues this cycle, so whatever is still outstanding afterwards is stale.
      drop_cnt_d = outstanding_q - CntW'(resp_fire);
      fifo_cnt_d = '0;
      fq_wptr_d  = '0;
      fq_rptr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_cnt_q    <= '0;
      pq_wptr_q     <= '0;
      pq_rptr_q     <= '0;
      fq_wptr_q     <= '0;
      fq_rptr_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fifo_cnt_q    <= fifo_cnt_d;
      pq_wptr_q     <= pq_wptr_d;
      pq_rptr_q     <= pq_rptr_d;
      fq_wptr_q     <= fq_wptr_d;
      fq_rptr_q     <= fq_rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      pq_mem_q[pq_wptr_q] <= fetch_pc_q;
    end
    if (push) begin
      fq_instr_q[fq_wptr_q] <= bus.imem_resp_data;
      fq_pc_q[fq_wptr_q]    <= pq_mem_q[pq_rptr_q];
    end
  end

  always_comb begin
    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = fetch_pc_q;
    bus.id_valid       = id_valid;
    bus.id_instr       = fq_instr_q[fq_rptr_q];
    bus.id_pc          = fq_pc_q[fq_rptr_q];
    bus.id_op          = fq_instr_q[fq_rptr_q][31:26];
    bus.id_funct       = fq_instr_q[fq_rptr_q][5:0];
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model with 1-cycle response latency and a scoreboard
// of expected {pc, instr} deliveries, compared whenever decode consumes an instruction.
module tb_fetch_stage;
  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC   (RstPc),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int req_count   = 0;
  int deliveries  = 0;
  bit auto_resp   = 1'b1;
  logic [31:0] mem_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, update model after the edge, then drive next inputs.
  task automatic step();
    logic        rf, sf, idf, redir;
    logic [31:0] ra, pc, w, op_exp, fn_exp;
    @(negedge clk);
    rf    = bus.imem_req_valid & bus.imem_req_ready;
    ra    = bus.imem_req_addr;
    sf    = bus.imem_resp_valid;
    redir = bus.redirect_valid;
    idf   = bus.id_valid & bus.id_ready & ~redir & ~rst;
    if (redir) check("req_valid_in_redirect", 32'(bus.imem_req_valid), 32'd0);
    if (idf) begin
      deliveries++;
      if (exp_q.size() == 0) begin
        check("id_unexpected", 32'(bus.id_valid), 32'd0);
      end else begin
        pc     = exp_q.pop_front();
        w      = mem_word(pc);
        op_exp = {26'd0, w[31:26]};
        fn_exp = {26'd0, w[5:0]};
        check("id_pc", bus.id_pc, pc);
        check("id_instr", bus.id_instr, w);
        check("id_op", {26'd0, bus.id_op}, op_exp);
        check("id_funct", {26'd0, bus.id_funct}, fn_exp);
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
    end else begin
      if (sf && mem_q.size() > 0) mem_q.delete(0);
      if (redir) exp_q.delete();
      if (rf) begin
        mem_q.push_back(ra);
        exp_q.push_back(ra);
        req_count++;
      end
    end
    bus.redirect_valid = 1'b0;
    if (auto_resp && !rst && mem_q.size() > 0) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(mem_q[0]);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end
  endtask

  task automatic wait_id(input string tag, input logic [31:0] pc);
    int n = 0;
    while (bus.id_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.id_valid), 32'd1);
    check(tag, bus.id_pc, pc);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(bus.id_valid), 32'd0);
  endtask

  initial begin
    int          d0, r0;
    logic [31:0] hold_instr, hold_pc, a;
    rst                 = 1'b1;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.id_ready        = 1'b1;

    // Reset and first fetch
    step();
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_id_valid", 32'(bus.id_valid), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("first_req_addr", bus.imem_req_addr, RstPc);
    check("id_idle_after_rst", 32'(bus.id_valid), 32'd0);
    step();
    check("id_before_resp", 32'(bus.id_valid), 32'd0);
    step();
    check("id_after_resp", 32'(bus.id_valid), 32'd1);
    check("first_id_pc", bus.id_pc, RstPc);

    // Streaming: one delivery per cycle
    repeat (4) step();
    d0 = deliveries;
    repeat (10) step();
    check("stream_rate", 32'(deliveries - d0), 32'd10);

    // Backpressure from decode
    bus.imem_req_ready = 1'b0;
    drain("drain_pre_bp");
    bus.id_ready       = 1'b0;
    bus.imem_req_ready = 1'b1;
    r0 = req_count;
    repeat (10) step();
    check("bp_req_count", 32'(req_count - r0), 32'(Depth));
    check("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
    hold_instr = bus.id_instr;
    hold_pc    = bus.id_pc;
    check("bp_head_pc", hold_pc, exp_q[0]);
    repeat (3) step();
    check("bp_instr_hold", bus.id_instr, hold_instr);
    check("bp_pc_hold", bus.id_pc, hold_pc);
    bus.id_ready = 1'b1;
    repeat (6) step();
    bus.imem_req_ready = 1'b0;
    drain("drain_bp");

    // Redirect with two requests outstanding
    auto_resp          = 1'b0;
    bus.imem_req_ready = 1'b1;
    step();
    step();
    check("redir_outstanding", 32'(mem_q.size()), 32'd2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    #1;
    check("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
    auto_resp = 1'b1;
    step();
    check("redir_next_addr", bus.imem_req_addr, 32'h0000_0100);
    check("redir_flushed", 32'(bus.id_valid), 32'd0);
    wait_id("redir_first_pc", 32'h0000_0100);
    bus.imem_req_ready = 1'b0;
    drain("drain_redir");

    // Redirect coinciding with a response and a decode pop
    bus.imem_req_ready = 1'b1;
    repeat (5) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0203;
    #1;
    check("redir2_id_valid", 32'(bus.id_valid), 32'd1);
    step();
    check("redir2_next_addr", bus.imem_req_addr, 32'h0000_0200);
    wait_id("redir2_first_pc", 32'h0000_0200);
    bus.imem_req_ready = 1'b0;
    drain("drain_redir2");
    check("redir2_credit", 32'(bus.imem_req_valid), 32'd1);

    // Memory stall holds the address
    bus.imem_req_ready = 1'b1;
    repeat (3) step();
    bus.imem_req_ready = 1'b0;
    #1;
    a = bus.imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_addr", bus.imem_req_addr, a);
      check("stall_valid", 32'(bus.imem_req_valid), 32'd1);
    end
    bus.imem_req_ready = 1'b1;
    repeat (4) step();

    // Reset mid-stream
    rst = 1'b1;
    step();
    check("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("mid_rst_id_valid", 32'(bus.id_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("restart_addr", bus.imem_req_addr, RstPc);
    wait_id("restart_first_pc", RstPc);
    bus.imem_req_ready = 1'b0;
    drain("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
